// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access over a req/ready handshake, load alignment and the MEM/WB register.
// The stall holds the EX_MEM inputs steady, so the bus fields are driven combinationally from them.
module mem_wb_stage #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            regWrite_EX_MEM,
   input  logic            memWrite_EX_MEM,
   input  logic            memRead_EX_MEM,
   input  logic            memToReg_EX_MEM,
   input  logic            jump_EX_MEM,
   input  logic [2:0]      funct3_EX_MEM,
   input  logic [RD_W-1:0] rd_EX_MEM,
   input  logic [XLEN-1:0] aluResult_EX_MEM,
   input  logic [XLEN-1:0] data2_EX_MEM,
   input  logic [XLEN-1:0] returnAddr_EX_MEM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_mem,
   output logic            regWrite_MEM_WB,
   output logic [RD_W-1:0] rd_MEM_WB,
   output logic [XLEN-1:0] writeData_MEM_WB,
   output logic            misalign_MEM_WB
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nx;
   logic acc, mis, is_b, is_h, sgn;
   logic [1:0] off;
   logic [7:0] ld_b;
   logic [15:0] ld_h;
   logic [XLEN-1:0] ld_data, wb_data;
   assign off  = aluResult_EX_MEM[1:0];
   assign acc  = memRead_EX_MEM | memWrite_EX_MEM;
   // funct3[1:0] picks the size; anything that is not B or H behaves as a word
   assign is_b = funct3_EX_MEM[1:0] == 2'b00;
   assign is_h = funct3_EX_MEM[1:0] == 2'b01;
   assign sgn  = ~funct3_EX_MEM[2];
   assign mis  = acc & (is_h ? off[0] : (~is_b & (off != 2'b00)));
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (state == IDLE) state_nx = (acc & ~mis & ~dmem_ready) ? WAIT : IDLE;
      else               state_nx = dmem_ready ? IDLE : WAIT;
   end
   always_comb begin
      dmem_req  = (state == WAIT) | (acc & ~mis);
      stall_mem = dmem_req & ~dmem_ready;
   end
   assign dmem_we    = memWrite_EX_MEM;
   assign dmem_addr  = {aluResult_EX_MEM[XLEN-1:2], 2'b00};
   assign dmem_wdata = is_b ? {(XLEN/8){data2_EX_MEM[7:0]}} :
                       is_h ? {(XLEN/16){data2_EX_MEM[15:0]}} : data2_EX_MEM;
   assign dmem_be    = ~memWrite_EX_MEM ? 4'b1111 :
                       is_b ? 4'b0001 << off :
                       is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign ld_b    = dmem_rdata[{off, 3'b000} +: 8];
   assign ld_h    = dmem_rdata[{off[1], 4'b0000} +: 16];
   assign ld_data = is_b ? {{(XLEN-8){ld_b[7] & sgn}}, ld_b} :
                    is_h ? {{(XLEN-16){ld_h[15] & sgn}}, ld_h} : dmem_rdata;
   assign wb_data = jump_EX_MEM ? returnAddr_EX_MEM :
                    memToReg_EX_MEM ? ld_data : aluResult_EX_MEM;
   // A stalled cycle inserts a bubble; a misaligned access keeps rd/data but never writes
   always_ff @(posedge clk) begin
      if (reset || stall_mem) begin
         regWrite_MEM_WB  <= 1'b0;
         rd_MEM_WB        <= '0;
         writeData_MEM_WB <= '0;
         misalign_MEM_WB  <= 1'b0;
      end else begin
         regWrite_MEM_WB  <= regWrite_EX_MEM & ~mis;
         rd_MEM_WB        <= rd_EX_MEM;
         writeData_MEM_WB <= wb_data;
         misalign_MEM_WB  <= mis;
      end
   end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of EX_MEM_reg and consumes its outputs.
- Issues loads and stores to the data-memory bus using a req/ready handshake. Aligns and sign-extends load data, and selects the writeback value.
- Registers the result into the MEM/WB outputs. Raises a stall to the hazard unit while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- regWrite_EX_MEM  in  1  register-write control from EX/MEM.
- memWrite_EX_MEM  in  1  store request.
- memRead_EX_MEM  in  1  load request.
- memToReg_EX_MEM  in  1  select load data for writeback.
- jump_EX_MEM  in  1  select returnAddr for writeback.
- funct3_EX_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_EX_MEM  in  RD_W  destination register.
- aluResult_EX_MEM  in  XLEN  effective address or ALU result.
- data2_EX_MEM  in  XLEN  store data.
- returnAddr_EX_MEM  in  XLEN  PC+4 for JAL/JALR.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address, {aluResult[31:2],2'b00}.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  memory accepts/completes the request this cycle.
- dmem_rdata  in  XLEN  load word, valid when dmem_ready=1.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- regWrite_MEM_WB  out  1  registered register-write enable.
- rd_MEM_WB  out  RD_W  registered destination.
- writeData_MEM_WB  out  XLEN  registered writeback value.
- misalign_MEM_WB  out  1  registered misaligned-access flag.

Behaviour:
- FSM states: IDLE, WAIT. Reset → IDLE.
- acc = memRead_EX_MEM | memWrite_EX_MEM. If both are set, memWrite takes priority for dmem_we; the load result is still written back.
- misaligned = (H/HU and addr[0]) or (W and addr[1:0]≠0). A misaligned access never asserts dmem_req.
- dmem_req = acc & ~misaligned in IDLE, and 1 in WAIT. dmem_addr, dmem_we, dmem_be and dmem_wdata are combinational from the EX_MEM inputs, which stay stable because they are held by the stall.
- done = dmem_req & dmem_ready. stall_mem = dmem_req & ~dmem_ready, so a same-cycle ready gives zero stall.
- IDLE→WAIT when dmem_req & ~dmem_ready. WAIT→IDLE when dmem_ready.
- Store byte lanes:
  - SB: wdata = {4{data2[7:0]}}, be = 1 << addr[1:0].
  - SH: wdata = {2{data2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = data2, be = 1111.
- Loads: be = 1111. The selected byte/half is taken from dmem_rdata by addr[1:0] and sign- or zero-extended per funct3. Undefined funct3 codes are treated as W.
- Writeback value: jump_EX_MEM ? returnAddr : memToReg ? loadData : aluResult.
- MEM/WB register updates on every rising edge:
  - reset=1: regWrite_MEM_WB=0, rd_MEM_WB=0, writeData_MEM_WB=0, misalign_MEM_WB=0.
  - stall_mem=1: insert a bubble — regWrite=0, misalign=0, rd=0, data=0.
  - misaligned access: regWrite=0, misalign=1, rd and data captured.
  - otherwise: capture regWrite_EX_MEM, rd_EX_MEM and the writeback value; misalign=0.
- Latency: one cycle from EX_MEM to MEM_WB when dmem_ready arrives in the same cycle; otherwise 1 + wait cycles.
- reset mid-WAIT: the next cycle is IDLE, dmem_req=0 and MEM_WB is cleared. Memory completes or drops the outstanding transfer.
- dmem_ready while dmem_req=0 is ignored.
- Writes to rd=0 pass through unchanged; the register file discards them.

Test Plan:
- LW, addr 0x100, ready same cycle, rdata 0xDEADBEEF, rd=5, memToReg=1 → no stall; next edge MEM_WB: regWrite=1, rd=5, data=0xDEADBEEF.
- LB, addr 0x103, rdata 0x80123456, ready after 3 wait cycles → stall_mem=1 for 3 cycles with bubbles in MEM_WB; then data=0xFFFFFF80. The LBU variant gives 0x00000080.
- SH, addr 0x202, data2 0x0000ABCD → dmem_we=1, addr=0x200, be=1100, wdata=0xABCDABCD; MEM_WB regWrite=0.
- LW, addr 0x101 → dmem_req never asserted, no stall; MEM_WB misalign=1, regWrite=0.
- JAL, returnAddr 0x44, rd=1, jump=1, no memory access → MEM_WB data=0x44, regWrite=1, rd=1.
- LW stalled in WAIT, reset=1 for one cycle → next cycle dmem_req=0, stall_mem=0, all MEM_WB outputs 0, state IDLE.
